// File: rtl/inst_queue.sv
// Fetch-side instruction queue in front of the decoder.
// Issues one icache word request at a time and buffers (address, instruction) pairs.
module inst_queue #(
    parameter int          QUEUE_BITS = 4,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        wrong_predicted,
    input  logic [31:0] correct_pc,
    input  logic        issue_signal,
    input  logic [31:0] next_pc,
    input  logic        jalr_stall,
    output logic        valid,
    output logic [31:0] inst_addr,
    output logic [31:0] inst,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_done,
    input  logic [31:0] fetch_inst
);

    localparam int DEPTH = 1 << QUEUE_BITS;
    localparam logic [QUEUE_BITS:0] FULL = {1'b1, {QUEUE_BITS{1'b0}}};
    localparam logic [QUEUE_BITS:0] ONE  = {{QUEUE_BITS{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t                state;
    state_t                state_n;
    logic [QUEUE_BITS-1:0] head;
    logic [QUEUE_BITS-1:0] tail;
    logic [QUEUE_BITS-1:0] head_nxt;
    logic [QUEUE_BITS:0]   count;
    logic [31:0]           fetch_pc;
    logic [31:0]           addr_mem [DEPTH];
    logic [31:0]           data_mem [DEPTH];

    logic        pop;
    logic        fill;
    logic        start;
    logic        mismatch;
    logic        redirect;
    logic [31:0] expect_pc;

    // The decoder holds the head itself while stalled on a JALR operand.
    logic unused_ok;
    assign unused_ok = jalr_stall;

    assign valid     = count != '0;
    assign inst_addr = valid ? addr_mem[head] : 32'h0;
    assign inst      = valid ? data_mem[head] : 32'h0;

    assign head_nxt  = head + 1'b1;
    assign pop       = rdy_in && issue_signal && valid;
    assign expect_pc = (count > ONE) ? addr_mem[head_nxt] : fetch_pc;
    assign mismatch  = pop && (next_pc != expect_pc);
    assign redirect  = wrong_predicted || mismatch;
    assign fill      = rdy_in && (state == WAIT) && fetch_done && !redirect;
    assign start     = rdy_in && (state == IDLE) && !redirect && (count < FULL);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_n = WAIT;
            end
            WAIT: begin
                // A redirect with the response already here needs no drop phase.
                if (fetch_done)
                    state_n = IDLE;
                else if (redirect)
                    state_n = DROP;
            end
            DROP: begin
                if (fetch_done)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            fetch_pc   <= RESET_PC;
            fetch_req  <= 1'b0;
            fetch_addr <= 32'h0;
        end else if (rdy_in) begin
            state     <= state_n;
            fetch_req <= state_n != IDLE;
            if (start)
                fetch_addr <= fetch_pc;
            if (redirect) begin
                head     <= tail;
                count    <= '0;
                fetch_pc <= wrong_predicted ? correct_pc : next_pc;
            end else begin
                if (pop)
                    head <= head_nxt;
                if (fill) begin
                    tail     <= tail + 1'b1;
                    fetch_pc <= fetch_pc + 32'd4;
                end
                count <= count + {{QUEUE_BITS{1'b0}}, fill}
                               - {{QUEUE_BITS{1'b0}}, pop};
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill) begin
            addr_mem[tail] <= fetch_addr;
            data_mem[tail] <= fetch_inst;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: icache model, decoder driver, issue monitor.
module tb_inst_queue;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        wrong_predicted;
    logic [31:0] correct_pc;
    logic        issue_signal;
    logic [31:0] next_pc;
    logic        jalr_stall;
    logic        valid;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_done;
    logic [31:0] fetch_inst;

    int          tests = 0;
    int          fails = 0;
    int          lat = 2;
    logic        resp_en = 1'b1;
    logic        prev_req = 1'b0;
    logic [31:0] req_log [$];
    logic [63:0] exp_q [$];

    inst_queue #(.QUEUE_BITS(4), .RESET_PC(32'h0)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .wrong_predicted (wrong_predicted),
        .correct_pc      (correct_pc),
        .issue_signal    (issue_signal),
        .next_pc         (next_pc),
        .jalr_stall      (jalr_stall),
        .valid           (valid),
        .inst_addr       (inst_addr),
        .inst            (inst),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .fetch_done      (fetch_done),
        .fetch_inst      (fetch_inst)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    // icache: answers each request lat cycles later with a single-cycle strobe
    initial begin
        fetch_done = 1'b0;
        fetch_inst = 32'h0;
        @(negedge clk_in);
        forever begin
            if (fetch_req && resp_en && rst_in) begin
                repeat (lat - 1) @(negedge clk_in);
                fetch_inst = inst_of(fetch_addr);
                fetch_done = 1'b1;
                @(negedge clk_in);
                fetch_done = 1'b0;
            end else begin
                @(negedge clk_in);
            end
        end
    end

    // monitor: compares each consumed head against the scoreboard, logs requests
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk_in);
            #2;
            if (rst_in && issue_signal && valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_issue: got %h expected none", inst_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_addr", inst_addr, e[63:32]);
                    check("issue_inst", inst, e[31:0]);
                end
            end
            if (fetch_req && !prev_req)
                req_log.push_back(fetch_addr);
            prev_req = fetch_req;
        end
    end

    task automatic do_reset();
        rst_in          = 1'b0;
        issue_signal    = 1'b0;
        wrong_predicted = 1'b0;
        jalr_stall      = 1'b0;
        resp_en         = 1'b1;
        lat             = 2;
        repeat (5) step();
        check("rst_valid", {31'b0, valid}, 32'h0);
        check("rst_req", {31'b0, fetch_req}, 32'h0);
        check("rst_faddr", fetch_addr, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_iaddr", inst_addr, 32'h0);
        req_log.delete();
        rst_in = 1'b1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] npc);
        int n = 0;
        while (!valid && n < 100) begin
            step();
            n++;
        end
        if (!valid) begin
            tests++;
            fails++;
            $display("FAIL issue_wait: got valid=0 expected valid=1");
            return;
        end
        exp_q.push_back({addr, inst_of(addr)});
        issue_signal = 1'b1;
        next_pc      = npc;
        step();
        issue_signal = 1'b0;
    endtask

    task automatic wait_count(input int n, input string name);
        int k = 0;
        while (dut.count != 5'(n) && k < 300) begin
            step();
            k++;
        end
        check(name, {27'b0, dut.count}, n);
    endtask

    task automatic wait_reqs(input int n, input string name);
        int k = 0;
        while (req_log.size() < n && k < 100) begin
            step();
            k++;
        end
        check(name, req_log.size(), n);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!valid && k < 100) begin
            step();
            k++;
        end
        check(name, {31'b0, valid}, 32'h1);
    endtask

    // queue holds 0x0..0xC with the request to 0x10 left unanswered
    task automatic hold_at_0x10();
        do_reset();
        wait_count(4, "hold_count");
        resp_en = 1'b0;
        repeat (2) step();
        check("hold_req", {31'b0, fetch_req}, 32'h1);
        check("hold_faddr", fetch_addr, 32'h10);
    endtask

    initial begin
        int k;
        rdy_in     = 1'b1;
        correct_pc = 32'h0;
        next_pc    = 32'h0;

        // reset release and first fills
        do_reset();
        k = 0;
        while (!fetch_done && k < 50) begin
            step();
            k++;
        end
        check("first_done_valid", {31'b0, valid}, 32'h0);
        step();
        check("first_valid", {31'b0, valid}, 32'h1);
        check("first_iaddr", inst_addr, 32'h0);
        check("first_inst", inst, inst_of(32'h0));
        wait_reqs(3, "req_cnt3");
        check("req0", req_log[0], 32'h0);
        check("req1", req_log[1], 32'h4);
        check("req2", req_log[2], 32'h8);

        // never issue: fills up to 16 then stops requesting
        wait_count(16, "full_count");
        repeat (10) step();
        check("full_req", {31'b0, fetch_req}, 32'h0);
        check("full_nreq", req_log.size(), 16);
        check("full_last", req_log[15], 32'h3C);
        check("full_head", inst_addr, 32'h0);

        // decoder redirect while a request is outstanding
        hold_at_0x10();
        issue(32'h0, 32'h100);
        check("redir_valid", {31'b0, valid}, 32'h0);
        check("redir_count", {27'b0, dut.count}, 32'h0);
        check("redir_req_hold", {31'b0, fetch_req}, 32'h1);
        check("redir_faddr_hold", fetch_addr, 32'h10);
        resp_en = 1'b1;
        wait_reqs(6, "redir_nreq");
        check("redir_req", req_log[5], 32'h100);
        wait_valid("redir_refill");
        check("redir_iaddr", inst_addr, 32'h100);
        check("redir_inst", inst, inst_of(32'h100));

        // ROB flush while a request is outstanding
        hold_at_0x10();
        correct_pc      = 32'h200;
        wrong_predicted = 1'b1;
        step();
        wrong_predicted = 1'b0;
        check("flush_valid", {31'b0, valid}, 32'h0);
        check("flush_req_hold", {31'b0, fetch_req}, 32'h1);
        check("flush_faddr_hold", fetch_addr, 32'h10);
        resp_en = 1'b1;
        wait_reqs(6, "flush_nreq");
        check("flush_req", req_log[5], 32'h200);
        wait_valid("flush_refill");
        check("flush_iaddr", inst_addr, 32'h200);
        check("flush_inst", inst, inst_of(32'h200));

        // jalr stall holds the head while the queue keeps filling
        do_reset();
        wait_count(3, "jalr_pre");
        issue(32'h0, 32'h4);
        issue(32'h4, 32'h8);
        jalr_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("jalr_iaddr", inst_addr, 32'h8);
            check("jalr_inst", inst, inst_of(32'h8));
        end
        jalr_stall = 1'b0;
        wait_count(16, "jalr_full");
        repeat (4) step();
        check("jalr_full_req", {31'b0, fetch_req}, 32'h0);
        check("jalr_full_head", inst_addr, 32'h8);

        // pop and fill on the same edge with count 3
        do_reset();
        k = 0;
        while (!(dut.count == 5'd3 && fetch_done) && k < 100) begin
            step();
            k++;
        end
        check("pf_found", {31'b0, fetch_done}, 32'h1);
        issue(32'h0, 32'h4);
        check("pf_count", {27'b0, dut.count}, 32'h3);
        check("pf_head", {28'b0, dut.head}, 32'h1);
        check("pf_tail", {28'b0, dut.tail}, 32'h4);
        check("pf_iaddr", inst_addr, 32'h4);

        // 40 sequential instructions through the wrapping pointers
        do_reset();
        for (int i = 0; i < 40; i++)
            issue(32'(i * 4), 32'(i * 4 + 4));
        step();
        check("stream_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
